// File: rtl/gray_ptr_receiver.sv
// Receiving end of a Gray-coded pointer crossing: synchronizes a remote Gray pointer,
// decodes it to binary and derives fill level, empty/full, update pulse and error flag.
module gray_ptr_receiver #(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] gray_in,
    input  logic [W-1:0] local_bin,
    input  logic         err_clr,
    output logic [W-1:0] bin_out,
    output logic [W-1:0] level,
    output logic         empty,
    output logic         full,
    output logic         ptr_inc,
    output logic         ptr_err
);

    localparam logic [W-1:0] HALF = W'(1) << (W - 1);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0] g_prev_q, g_prev_d;
    logic [W-1:0] bin_out_q, bin_out_d;
    logic         ptr_inc_q, ptr_inc_d;
    logic         ptr_err_q, ptr_err_d;
    logic [W-1:0] g_last;
    logic [W-1:0] g_diff;
    logic         multi_bit;

    // Plain flop chain: nothing may look at gray_in before the last stage.
    always_comb begin
        sync_d    = '0;
        sync_d[0] = gray_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        g_last             = sync_q[SYNC_STAGES-1];
        bin_out_d          = '0;
        bin_out_d[W-1]     = g_last[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            bin_out_d[i] = bin_out_d[i+1] ^ g_last[i];
        end
        g_prev_d  = g_last;
        g_diff    = g_last ^ g_prev_q;
        // More than one bit set iff clearing the lowest set bit leaves something.
        multi_bit = |(g_diff & (g_diff - W'(1)));
        ptr_inc_d = |g_diff;
        if (multi_bit) begin
            ptr_err_d = 1'b1;
        end else if (err_clr) begin
            ptr_err_d = 1'b0;
        end else begin
            ptr_err_d = ptr_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            g_prev_q  <= '0;
            bin_out_q <= '0;
            ptr_inc_q <= 1'b0;
            ptr_err_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            g_prev_q  <= g_prev_d;
            bin_out_q <= bin_out_d;
            ptr_inc_q <= ptr_inc_d;
            ptr_err_q <= ptr_err_d;
        end
    end

    // Unregistered so the local pointer's own movement is reflected immediately.
    always_comb begin
        level = bin_out_q - local_bin;
        empty = (level == '0);
        full  = (level == HALF);
    end

    assign bin_out = bin_out_q;
    assign ptr_inc = ptr_inc_q;
    assign ptr_err = ptr_err_q;

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Scoreboard bench for gray_ptr_receiver: a driver pushes per-cycle expectations from a
// sample-history model, and a negedge monitor pops and compares them.
module tb_gray_ptr_receiver;

    localparam int W    = 4;
    localparam int SYNC = 2;
    localparam int MOD  = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] gray_in;
    logic [W-1:0] local_bin;
    logic         err_clr;
    logic [W-1:0] bin_out;
    logic [W-1:0] level;
    logic         empty;
    logic         full;
    logic         ptr_inc;
    logic         ptr_err;

    gray_ptr_receiver #(.W(W), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .local_bin (local_bin),
        .err_clr   (err_clr),
        .bin_out   (bin_out),
        .level     (level),
        .empty     (empty),
        .full      (full),
        .ptr_inc   (ptr_inc),
        .ptr_err   (ptr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned binv;
        int unsigned lvl;
        bit          emp;
        bit          ful;
        bit          inc;
        bit          err;
    } exp_t;

    exp_t        expQ[$];
    int unsigned hist[$];
    int unsigned binM;
    bit          incM;
    bit          errM;
    int unsigned curGray;
    int unsigned curLocal;
    bit          curClr;
    int          checkCount = 0;
    int          passCount  = 0;
    bit          monOn      = 1'b0;

    function automatic int unsigned toGray(input int unsigned n);
        return (n ^ (n >> 1)) % MOD;
    endfunction

    // Inverse found by search over all codes rather than by a bitwise prefix XOR.
    function automatic int unsigned fromGray(input int unsigned g);
        for (int n = 0; n < MOD; n++) begin
            if (toGray(n) == g) return n;
        end
        return 0;
    endfunction

    function automatic void checkOutput(input string name, input int unsigned actual,
                                        input int unsigned expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endfunction

    function automatic void modelReset();
        hist.delete();
        for (int i = 0; i < SYNC + 2; i++) hist.push_back(0);
        binM = 0;
        incM = 1'b0;
        errM = 1'b0;
    endfunction

    // hist[k] holds the gray value sampled (SYNC+1-k) edges ago; bin_out reflects hist[1].
    function automatic void modelEdge();
        int unsigned cur;
        int unsigned prev;
        hist.push_back(curGray);
        void'(hist.pop_front());
        cur  = hist[1];
        prev = hist[0];
        binM = fromGray(cur);
        incM = (cur != prev);
        if ($countones(cur ^ prev) > 1) errM = 1'b1;
        else if (curClr)                errM = 1'b0;
    endfunction

    function automatic exp_t expectNow();
        exp_t e;
        e.binv = binM;
        e.lvl  = (binM + MOD - curLocal) % MOD;
        e.emp  = (e.lvl == 0);
        e.ful  = (e.lvl == MOD / 2);
        e.inc  = incM;
        e.err  = errM;
        return e;
    endfunction

    task automatic applyStimulus(input bit rstv, input int unsigned g, input int unsigned lb,
                                 input bit clr, input bit midRst);
        exp_t e;
        @(posedge clk);
        if (rst_n === 1'b1) modelEdge();
        #1;
        rst_n     = rstv;
        gray_in   = W'(g);
        local_bin = W'(lb);
        err_clr   = clr;
        curGray   = g % MOD;
        curLocal  = lb % MOD;
        curClr    = clr;
        if (!rstv) modelReset();
        if (midRst) begin
            #1;
            rst_n = 1'b0;
            #1;
            modelReset();
            e = expectNow();
            checkOutput("async_rst_bin", bin_out, e.binv);
            checkOutput("async_rst_inc", ptr_inc, e.inc);
            checkOutput("async_rst_err", ptr_err, e.err);
            checkOutput("async_rst_level", level, e.lvl);
            checkOutput("async_rst_empty", empty, e.emp);
            checkOutput("async_rst_full", full, e.ful);
        end
        expQ.push_back(expectNow());
    endtask

    task automatic holdCycles(input int n, input int unsigned g, input int unsigned lb);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, g, lb, 1'b0, 1'b0);
    endtask

    // Monitor: every negedge pops one expectation and compares all outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (monOn) begin
                if (expQ.size() == 0) begin
                    checkOutput("scoreboard_underrun", 0, 1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("bin_out", bin_out, e.binv);
                    checkOutput("level", level, e.lvl);
                    checkOutput("empty", empty, e.emp);
                    checkOutput("full", full, e.ful);
                    checkOutput("ptr_inc", ptr_inc, e.inc);
                    checkOutput("ptr_err", ptr_err, e.err);
                end
            end
        end
    end

    initial begin
        int unsigned rc;
        int unsigned seq[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
        rst_n     = 1'b0;
        gray_in   = W'(5);
        local_bin = '0;
        err_clr   = 1'b0;
        curGray   = 5;
        curLocal  = 0;
        curClr    = 1'b0;
        modelReset();
        monOn     = 1'b1;

        // Reset held with a nonzero remote pointer, then release.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5, 0, 1'b0, 1'b0);
        holdCycles(6, 5, 0);

        // Gray count sequence, one step per four clocks.
        foreach (seq[i]) holdCycles(4, seq[i], 0);
        applyStimulus(1'b1, 4, 0, 1'b1, 1'b0);
        holdCycles(4, 4, 0);

        // Full/empty with the local pointer ahead across the wrap.
        holdCycles(5, 6, 12);
        holdCycles(2, 6, 4);
        holdCycles(5, 8, 4);
        applyStimulus(1'b1, 8, 4, 1'b1, 1'b0);
        holdCycles(5, 0, 4);
        holdCycles(5, 0, 15);

        // Illegal two-bit jump, return to legal steps, then clear.
        holdCycles(5, 3, 0);
        holdCycles(5, 2, 0);
        applyStimulus(1'b1, 2, 0, 1'b1, 1'b0);
        holdCycles(4, 2, 0);

        // Set beats clear: clear held across another illegal jump.
        holdCycles(4, 3, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 0, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 0, 0, 1'b1, 1'b0);
        holdCycles(3, 0, 0);

        // Reach bin_out 7 with ptr_err set, then reset between edges.
        holdCycles(5, 4, 0);
        applyStimulus(1'b1, 4, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 4, 0, 1'b0, 1'b0);
        holdCycles(6, 4, 0);

        // Randomized traffic: mostly legal counting, occasional jumps and clears.
        rc = 7;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 40) rc = (rc + 1) % MOD;
            if ($urandom_range(99) < 3)  rc = $urandom_range(MOD - 1);
            applyStimulus(1'b1, toGray(rc), $urandom_range(MOD - 1),
                          ($urandom_range(99) < 10), ($urandom_range(999) < 5));
        end

        @(negedge clk);
        #1;
        monOn = 1'b0;
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/gray_ptr_receiver.md
Name: gray_ptr_receiver

Overview:
- Receiving end of a Gray-coded pointer crossing: takes a Gray pointer produced in another clock domain and brings it into the local domain.
- Synchronizes the pointer through a flop chain, decodes it to binary, and compares it with the local binary pointer.
- Produces fill level, empty and full flags, an update pulse and a sticky protocol-error flag.
- Used on both async FIFO sides: the read side receives the write pointer, the write side receives the read pointer.

Parameters:
- W, 4, pointer width including the wrap bit (FIFO depth = 2^(W-1)); legal W >= 1.
- SYNC_STAGES, 2, synchronizer flop count; legal >= 2.

Ports:
- clk  input  1  local clock
- rst_n  input  1  asynchronous active-low reset
- gray_in  input  W  Gray pointer from the remote domain, asynchronous to clk
- local_bin  input  W  local binary pointer, synchronous to clk
- err_clr  input  1  clears ptr_err
- bin_out  output  W  decoded, synchronized remote pointer (registered)
- level  output  W  (bin_out - local_bin) mod 2^W
- empty  output  1  level == 0
- full  output  1  level == 2^(W-1)
- ptr_inc  output  1  one-cycle pulse when the synchronized pointer changes
- ptr_err  output  1  sticky flag: illegal Gray transition seen

Behaviour:
- Reset (rst_n low, asynchronous):
  - all sync stages, previous-Gray register, bin_out, ptr_inc and ptr_err go to 0.
  - level = local_bin negated mod 2^W; empty and full follow from that.
  - With local_bin = 0: level 0, empty 1, full 0.
  - Gray 0 decodes to binary 0, which matches the remote encoder's reset.
- Synchronizer:
  - gray_in -> s[0] -> ... -> s[SYNC_STAGES-1], one flop per clk, no logic between stages.
  - gray_in is never decoded or compared before the last stage.
- Decode register:
  - Each cycle: g_prev <= s[last].
  - bin_out <= gray2bin(s[last]), where bit W-1 = g[W-1] and bit i = bin[i+1] ^ g[i] for i = W-2 down to 0.
  - W == 1: binary equals Gray.
- Latency: a stable gray_in change shows on bin_out SYNC_STAGES+1 rising edges later (3 at default).
- level/empty/full:
  - Combinational from registered bin_out and the current local_bin.
  - No registering, so the local pointer's own effect is seen in the same cycle; this gives conservative flags.
  - Subtraction is W-bit modulo; no saturation.
- ptr_inc:
  - Registered, asserted for exactly one cycle when s[last] != g_prev.
  - Aligned with the cycle in which bin_out shows the new value.
- Error check:
  - If s[last] and g_prev differ in more than one bit, ptr_err <= 1 on the same edge that bin_out updates.
  - A legal remote encoder changes one bit per remote-clock edge. If the remote clock is faster than clk, multi-bit differences can legally arise, so ptr_err is only meaningful when remote clock <= local clock. Integrators must gate its use accordingly.
- ptr_err priority: sticky until err_clr; set has priority over clear in the same cycle; clear takes effect the next edge.
- Wrap-around: binary 2^W-1 -> 0 (Gray 100..0 -> 000..0) is a legal one-bit step; no error, ptr_inc pulses.
- Level wraps correctly across the pointer wrap, e.g. W=4, bin_out=1, local_bin=15 -> level 2.
- Levels above 2^(W-1) are not reachable with a correct FIFO. The block does not flag them; full checks exact equality only.
- Reset mid-operation: immediate asynchronous clear of all state, regardless of sync-chain contents. Normal capture resumes on the first edge after rst_n rises. The synchronizer reset release is handled outside this block.

Test Plan:
- Reset, W=4, SYNC_STAGES=2: hold rst_n low with gray_in=5, local_bin=0 -> bin_out 0, ptr_inc 0, ptr_err 0, level 0, empty 1, full 0. Release, gray_in stays 5 -> bin_out 6 exactly 3 edges after release, ptr_inc one pulse in that cycle.
- Count sequence: gray_in steps 0,1,3,2,6,7,5,4, one step per 4 clk, local_bin 0 -> bin_out 0..7 in order, each 3 edges after its step. ptr_inc one pulse per step, ptr_err 0, level equals bin_out.
- Full/empty with wrap: local_bin=12, gray_in=Gray(4)=6 -> level 8, full 1, empty 0. Then local_bin=4 -> level 0, empty 1, same cycle (combinational). Gray 8 -> 0 transition gives no ptr_err.
- Illegal jump: gray_in 0 -> 3 (two bits) -> ptr_err 1 in the same cycle bin_out becomes 2, and stays 1 after gray_in returns to legal steps. Pulse err_clr -> ptr_err 0 on the next edge.
- Set beats clear: err_clr held high while gray_in jumps 3 -> 0 -> ptr_err 1 on the detecting edge. Release err_clr, pulse it once -> ptr_err 0.
- Mid-operation reset: bin_out=7, ptr_err=1, assert rst_n low asynchronously between edges -> all state 0 immediately, without waiting for a clk edge. After release with gray_in=4 -> bin_out 7 after 3 edges, ptr_err 0.
